// File: rtl/awg_pkg.sv
// Shared AWG definitions: sweep modes and the NCO tuning-word width.
package awg_pkg;

  typedef enum logic [1:0] {
    SWP_SINGLE,
    SWP_SAW,
    SWP_TRI,
    SWP_RSVD
  } sweep_mode_e;

  localparam int unsigned NCO_FREQ_W = 28;

  typedef logic [NCO_FREQ_W-1:0] freq_word_t;

endpackage

// File: rtl/freq_step_clamp.sv
// One sweep step toward a limit, computed one bit wider than the tuning word.
// Saturates at the limit, so the result never overshoots and never wraps.
module freq_step_clamp #(
  parameter int unsigned W = 28
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] step,
  input  logic [W-1:0] limit,
  input  logic         dir,      // 1 = stepping downward
  output logic [W-1:0] next,
  output logic         at_limit
);

  logic [W:0] sum;
  logic [W:0] diff;

  always_comb begin
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, step};
    next = limit;
    if (dir) begin
      // A borrow into the top bit means the subtraction went below zero.
      if (!diff[W] && (diff[W-1:0] > limit)) begin
        next = diff[W-1:0];
      end
    end else begin
      if (sum < {1'b0, limit}) begin
        next = sum[W-1:0];
      end
    end
    at_limit = (cur == limit);
  end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Chirp generator feeding the NCO tuning word: CW, single, sawtooth and triangle sweeps
// from a config loaded over valid/ready, with a phase-reset strobe at each sweep origin.
module freq_sweep_ctrl
  import awg_pkg::*;
#(
  parameter int unsigned FREQ_W  = NCO_FREQ_W,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FREQ_W-1:0]  cfg_start,
  input  logic [FREQ_W-1:0]  cfg_stop,
  input  logic [FREQ_W-1:0]  cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic               start,
  input  logic               abort,
  output logic [FREQ_W-1:0]  freq,
  output logic               accum_rst,
  output logic               sweep_trig,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q;
  logic [FREQ_W-1:0]  start_q;
  logic [FREQ_W-1:0]  stop_q;
  logic [FREQ_W-1:0]  step_q;
  logic [DWELL_W-1:0] dwell_q;
  sweep_mode_e        mode_q;
  logic               dir_q;
  logic               back_q;   // 1 while a triangle heads back toward start_q
  logic [DWELL_W-1:0] cnt_q;

  logic               hs;
  logic [FREQ_W-1:0]  eff_start;
  logic               degenerate;
  logic               dwell_end;
  logic               bwd_dir;
  logic [FREQ_W-1:0]  fwd_next;
  logic               fwd_at;
  logic [FREQ_W-1:0]  bwd_next;
  logic               bwd_at;

  assign hs         = cfg_valid & cfg_ready & ~abort;
  // A handshake in the start cycle must feed the new origin straight into freq.
  assign eff_start  = hs ? cfg_start : start_q;
  assign degenerate = (step_q == '0) || (start_q == stop_q);
  assign dwell_end  = (cnt_q == dwell_q);
  assign bwd_dir    = ~dir_q;

  freq_step_clamp #(
    .W(FREQ_W)
  ) u_fwd_clamp (
    .cur      (freq),
    .step     (step_q),
    .limit    (stop_q),
    .dir      (dir_q),
    .next     (fwd_next),
    .at_limit (fwd_at)
  );

  freq_step_clamp #(
    .W(FREQ_W)
  ) u_bwd_clamp (
    .cur      (freq),
    .step     (step_q),
    .limit    (start_q),
    .dir      (bwd_dir),
    .next     (bwd_next),
    .at_limit (bwd_at)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      mode_q  <= SWP_SINGLE;
      dir_q   <= 1'b0;
    end else if (hs) begin
      start_q <= cfg_start;
      stop_q  <= cfg_stop;
      step_q  <= cfg_step;
      dwell_q <= cfg_dwell;
      mode_q  <= sweep_mode_e'(cfg_mode);
      dir_q   <= (cfg_stop < cfg_start);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cfg_ready  <= 1'b0;
      freq       <= '0;
      accum_rst  <= 1'b0;
      sweep_trig <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      back_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      accum_rst  <= 1'b0;
      sweep_trig <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        state_q   <= IDLE;
        cfg_ready <= 1'b1;
        freq      <= '0;
        busy      <= 1'b0;
        back_q    <= 1'b0;
        cnt_q     <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            cfg_ready <= 1'b1;
            if (start) begin
              state_q    <= RUN;
              cfg_ready  <= 1'b0;
              freq       <= eff_start;
              accum_rst  <= 1'b1;
              sweep_trig <= 1'b1;
              busy       <= 1'b1;
              back_q     <= 1'b0;
              cnt_q      <= '0;
            end
          end
          RUN: begin
            if (degenerate) begin
              cnt_q <= '0;
            end else if (!dwell_end) begin
              cnt_q <= cnt_q + DWELL_W'(1);
            end else begin
              cnt_q <= '0;
              if (!back_q) begin
                if (!fwd_at) begin
                  freq <= fwd_next;
                end else begin
                  case (mode_q)
                    SWP_SAW: begin
                      freq       <= start_q;
                      accum_rst  <= 1'b1;
                      sweep_trig <= 1'b1;
                    end
                    SWP_TRI: begin
                      // Leave the far endpoint after a single dwell.
                      freq <= bwd_next;
                      if (bwd_next == start_q) begin
                        accum_rst  <= 1'b1;
                        sweep_trig <= 1'b1;
                      end else begin
                        back_q <= 1'b1;
                      end
                    end
                    default: begin
                      state_q   <= IDLE;
                      cfg_ready <= 1'b1;
                      busy      <= 1'b0;
                      done      <= 1'b1;
                    end
                  endcase
                end
              end else if (bwd_at) begin
                back_q <= 1'b0;
              end else begin
                freq <= bwd_next;
                // Arriving back at the origin is the reload point of the triangle.
                if (bwd_next == start_q) begin
                  back_q     <= 1'b0;
                  accum_rst  <= 1'b1;
                  sweep_trig <= 1'b1;
                end
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
